shift_rot_flags_pipe: RTL and testbench
=======================================

# shift_rot_flags_pipe

Two-stage pipelined shift/rotate execution unit with x86 status-flag generation. It supports SHL, SHR, SAR, ROL and ROR on 8/16/32-bit operands, and 64-bit operands when WIDTH=64. It sits in the execute stage beside the ALU, takes an operand, a count and an opcode under a valid/ready handshake, and returns the result, six flags and a per-flag write mask two cycles later. It supersedes the single-cycle combinational right shifter.

## Interface
- WIDTH, 32: datapath width. Legal values are 32 and 64.
- CNT_W, $clog2(WIDTH): count input width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of both pipeline stages.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  3  operation: 0 SHL, 1 SHR, 2 SAR, 3 ROL, 4 ROR. Codes 5–7 are reserved and treated as SHL.
- in_size  in  2  operand size: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = 64-bit (64-bit legal only when WIDTH=64, otherwise treated as 32-bit).
- in_a  in  WIDTH  operand; only the low size bits are used.
- in_cnt  in  CNT_W  raw shift count.
- in_tag  in  4  opaque tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  WIDTH  result, zero-extended above the operand size.
- out_flags  out  6  flags: [0] CF, [1] PF, [2] AF, [3] ZF, [4] SF, [5] OF.
- out_flags_we  out  6  per-flag write enable.
- out_tag  out  4  returned tag.

## Operation
- Count masking: cnt = in_cnt & 0x1F for sizes 0–2; cnt = in_cnt & 0x3F for size 3. Let N be the operand size in bits.
- cnt == 0: out_res = operand and out_flags_we = 0. The result still flows through the pipeline.
- SHL: res = a << cnt. CF = a[N-cnt], or 0 if cnt > N. OF = res[N-1] ^ CF.
- SHR: res = a >> cnt. CF = a[cnt-1], or 0 if cnt > N. OF = a[N-1].
- SAR: sign-fill shift. If cnt ≥ N, res is all sign bits and CF = sign. Otherwise CF = a[cnt-1]. OF = 0.
- Shift flags: SF = res[N-1]; ZF = (res[N-1:0] == 0); PF = even parity of res[7:0], for every size; AF = 0.
- Shift write enable: out_flags_we = 6'b111111 when cnt ≠ 0.
- ROL / ROR: effective rotate = cnt mod N. The result is computed with the effective rotate; CF and OF are computed for any nonzero cnt, including cnt that is a multiple of N.
  - ROL: CF = res[0], OF = res[N-1] ^ CF.
  - ROR: CF = res[N-1], OF = res[N-1] ^ res[N-2].
  - Write enable: out_flags_we = 6'b100001 (CF and OF only). The other flag bits are driven 0.
- Stage 1 (S1): mask the count, size-extend the operand, run a log2 barrel shifter over WIDTH+1 bits to produce the result and the carry bit, and register the result, carry, op, size and tag.
- Stage 2 (S2): compute ZF, SF, PF, OF and the masks, and register them into the output stage.

## Timing
- Latency is 2 cycles: an input accepted at edge T produces out_valid at T+2 when no stall occurs. Throughput is 1 per cycle.
- Handshake: a transfer occurs when valid && ready on the same edge. S2 holds its outputs stable while out_valid && !out_ready.
- Stall propagation: in_ready = !s1_valid || (!s2_valid || out_ready). S1 advances only when S2 is empty or draining. There is no combinational path from in_valid to out_*.
- Reset (asynchronous): s1_valid = s2_valid = 0; out_valid = 0, in_ready = 1. out_res, out_flags, out_flags_we and out_tag reset to 0.
- flush: clears s1_valid and s2_valid at the next edge. An input presented in the same cycle is dropped. in_ready is 1 in the cycle after the flush.
- Reset asserted mid-operation discards all in-flight results; no partial output appears after reset deasserts.
- Back-to-back: with out_ready held high, N consecutive inputs produce N consecutive outputs in order, tags preserved.

## Test plan
- SHL, size 0, a=0x81, cnt=1 -> res=0x02, CF=1, OF=1, ZF=0, SF=0, PF=0, we=0x3F, out_valid at T+2.
- SAR, size 1, a=0x8000, cnt=20 -> res=0xFFFF, CF=1, SF=1, OF=0, PF=1. Then SHR, size 2, a=0x80000001, cnt=0x21 (masked to 1) -> res=0x40000000, CF=1, OF=1.
- ROR, size 0, a=0x01, cnt=9 -> res=0x80, CF=1, OF=1, we=0x21. Then ROL, size 2, a=0x12345678, cnt=0 -> res unchanged, we=0.
- Back-pressure: issue 4 tagged ops while out_ready=0 for 5 cycles -> in_ready falls after 2 accepts, out_* held stable. After out_ready rises, all 4 results emerge in tag order with no loss or duplication.
- flush while both stages are full and in_valid=1 -> no out_valid in the following 2 cycles, in_ready=1 the next cycle.
- rst pulse asynchronous to clk, mid-stream -> out_valid=0 immediately, all outputs 0. The first post-reset op returns correctly at T+2.

Source files
------------

// File: rtl/shift_rot_flags_pipe.sv
// Two-stage shift/rotate unit with x86 flag generation.
// S1 computes the result and carry; S2 derives the remaining flags and the write masks.
module shift_rot_flags_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_size,
  input  logic [WIDTH-1:0] in_a,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [3:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [5:0]       out_flags,
  output logic [5:0]       out_flags_we,
  output logic [3:0]       out_tag
);

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_SAR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  function automatic logic [6:0] size_bits(input logic [1:0] s);
    case (s)
      2'd0:    size_bits = 7'd8;
      2'd1:    size_bits = 7'd16;
      2'd2:    size_bits = 7'd32;
      default: size_bits = 7'd64;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    size_mask = WIDTH'(8'hFF);
      2'd1:    size_mask = WIDTH'(16'hFFFF);
      2'd2:    size_mask = WIDTH'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase
  endfunction

  // Stage 1 registers
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_res_reg;
  logic             s1_cf_reg;
  logic             s1_amsb_reg;
  logic [2:0]       s1_op_reg;
  logic [1:0]       s1_size_reg;
  logic [3:0]       s1_tag_reg;
  logic             s1_nz_reg;

  logic             s2_adv;
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid_reg || s2_adv;

  // Stage 1 combinational datapath
  logic [1:0]       size_next;
  logic [2:0]       op_next;
  logic [5:0]       cnt_next;
  logic [6:0]       n_bits;
  logic [6:0]       rot;
  logic [6:0]       rot_c;
  logic [WIDTH-1:0] mask_in;
  logic [WIDTH-1:0] msb_in;
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] a_sx;
  logic [WIDTH-1:0] rol_v;
  logic [WIDTH-1:0] ror_v;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH:0]   shl_x;
  logic [WIDTH:0]   shr_x;
  logic [WIDTH:0]   sar_x;
  logic             sign_in;
  logic             cf_next;

  always_comb begin
    size_next = (in_size == 2'd3 && WIDTH != 64) ? 2'd2 : in_size;
    op_next   = (in_op > OP_ROR) ? OP_SHL : in_op;
    cnt_next  = 6'(in_cnt) & ((size_next == 2'd3) ? 6'h3F : 6'h1F);
    n_bits    = size_bits(size_next);
    mask_in   = size_mask(size_next);
    msb_in    = mask_in ^ (mask_in >> 1);
    a_n       = in_a & mask_in;
    sign_in   = |(a_n & msb_in);
    a_sx      = a_n | (sign_in ? ~mask_in : '0);
    // The extra bit below/above the operand catches the last bit shifted out.
    shl_x     = {1'b0, a_n} << cnt_next;
    shr_x     = {a_n, 1'b0} >> cnt_next;
    sar_x     = $unsigned($signed({a_sx, 1'b0}) >>> cnt_next);
    rot       = 7'(cnt_next) & (n_bits - 7'd1);
    rot_c     = n_bits - rot;
    rol_v     = (a_n << rot) | (a_n >> rot_c);
    ror_v     = (a_n >> rot) | (a_n << rot_c);
    case (op_next)
      OP_SHR: begin
        res_next = shr_x[WIDTH:1];
        cf_next  = shr_x[0];
      end
      OP_SAR: begin
        res_next = sar_x[WIDTH:1] & mask_in;
        cf_next  = sar_x[0];
      end
      OP_ROL: begin
        res_next = rol_v & mask_in;
        cf_next  = res_next[0];
      end
      OP_ROR: begin
        res_next = ror_v & mask_in;
        cf_next  = |(res_next & msb_in);
      end
      default: begin
        res_next = shl_x[WIDTH-1:0] & mask_in;
        cf_next  = |(shl_x & {msb_in, 1'b0});
      end
    endcase
  end

  // Stage 2 combinational flag generation
  logic [WIDTH-1:0] msb_s1;
  logic             res_msb;
  logic             res_msb2;
  logic             of_next;
  logic [5:0]       flags_next;
  logic [5:0]       we_next;

  always_comb begin
    msb_s1     = size_mask(s1_size_reg) ^ (size_mask(s1_size_reg) >> 1);
    res_msb    = |(s1_res_reg & msb_s1);
    res_msb2   = |(s1_res_reg & (msb_s1 >> 1));
    of_next    = 1'b0;
    flags_next = 6'b0;
    we_next    = 6'b0;
    if (s1_nz_reg) begin
      case (s1_op_reg)
        OP_ROL: begin
          flags_next = {res_msb ^ s1_cf_reg, 4'b0, s1_cf_reg};
          we_next    = 6'b100001;
        end
        OP_ROR: begin
          flags_next = {res_msb ^ res_msb2, 4'b0, s1_cf_reg};
          we_next    = 6'b100001;
        end
        default: begin
          if (s1_op_reg == OP_SHR)      of_next = s1_amsb_reg;
          else if (s1_op_reg == OP_SHL) of_next = res_msb ^ s1_cf_reg;
          flags_next = {of_next, res_msb, (s1_res_reg == '0), 1'b0,
                        ~^s1_res_reg[7:0], s1_cf_reg};
          we_next    = 6'b111111;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_res_reg   <= '0;
      s1_cf_reg    <= 1'b0;
      s1_amsb_reg  <= 1'b0;
      s1_op_reg    <= 3'd0;
      s1_size_reg  <= 2'd0;
      s1_tag_reg   <= 4'd0;
      s1_nz_reg    <= 1'b0;
      out_valid    <= 1'b0;
      out_res      <= '0;
      out_flags    <= 6'b0;
      out_flags_we <= 6'b0;
      out_tag      <= 4'd0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_res_reg  <= res_next;
          s1_cf_reg   <= cf_next;
          s1_amsb_reg <= sign_in;
          s1_op_reg   <= op_next;
          s1_size_reg <= size_next;
          s1_tag_reg  <= in_tag;
          s1_nz_reg   <= (cnt_next != 6'd0);
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_res      <= s1_res_reg;
          out_flags    <= flags_next;
          out_flags_we <= we_next;
          out_tag      <= s1_tag_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_rot_flags_pipe.sv
// Bench for shift_rot_flags_pipe: directed vectors, pipeline corner cases and
// randomized traffic checked against a bit-serial reference model.
module tb_shift_rot_flags_pipe;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_size;
  logic [31:0] in_a, out_res;
  logic [4:0]  in_cnt;
  logic [3:0]  in_tag, out_tag;
  logic [5:0]  out_flags, out_flags_we;

  shift_rot_flags_pipe #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_size(in_size), .in_a(in_a), .in_cnt(in_cnt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flags(out_flags), .out_flags_we(out_flags_we), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] a;
    logic [4:0]  cnt;
    logic [31:0] res;
    logic [5:0]  flags;
    logic [5:0]  we;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  flags;
    logic [5:0]  we;
    logic [3:0]  tag;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    n_out = 0;
  exp_t  exp_q[$];
  exp_t  pend;
  bit    accepted, lat_on, rand_ready;
  logic [3:0] tag_ctr = 4'd0;
  vec_t  vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Reference: shifts/rotates applied one bit position at a time.
  function automatic exp_t model(input logic [2:0] op, input logic [1:0] size,
                                 input logic [31:0] a, input logic [4:0] cnt);
    exp_t e;
    int n, ones;
    logic [2:0] o;
    logic [31:0] mask, v;
    logic cf, of, msb0;
    e = '{default: 0};
    n = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    v = a & mask;
    msb0 = v[n-1];
    cf = 1'b0;
    of = 1'b0;
    o = (op > 3'd4) ? 3'd0 : op;
    case (o)
      3'd0: begin
        for (int i = 0; i < int'(cnt); i++) begin cf = v[n-1]; v = (v << 1) & mask; end
        of = v[n-1] ^ cf;
      end
      3'd1: begin
        for (int i = 0; i < int'(cnt); i++) begin cf = v[0]; v = v >> 1; end
        of = msb0;
      end
      3'd2: begin
        for (int i = 0; i < int'(cnt); i++) begin
          cf = v[0];
          v = (v >> 1) | (msb0 ? (32'h1 << (n - 1)) : 32'h0);
        end
      end
      3'd3: begin
        for (int i = 0; i < int'(cnt) % n; i++) v = ((v << 1) | {31'b0, v[n-1]}) & mask;
        cf = v[0];
        of = v[n-1] ^ cf;
      end
      default: begin
        for (int i = 0; i < int'(cnt) % n; i++) v = (v >> 1) | (v[0] ? (32'h1 << (n - 1)) : 32'h0);
        cf = v[n-1];
        of = v[n-1] ^ v[n-2];
      end
    endcase
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(v[i]);
    e.res = v;
    if (cnt != 5'd0) begin
      if (o < 3'd3) begin
        e.flags = {of, v[n-1], (v == 32'h0), 1'b0, (ones % 2 == 0), cf};
        e.we    = 6'b111111;
      end else begin
        e.flags = {of, 4'b0, cf};
        e.we    = 6'b100001;
      end
    end
    return e;
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (in_valid && in_ready && !flush && !rst) begin
      pend.acc_cyc = cyc;
      exp_q.push_back(pend);
      accepted = 1'b1;
    end
    if (out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got tag %0d, want no output", out_tag);
      end else begin
        e = exp_q.pop_front();
        n_out++;
        $display("tx tag=%0d res=%h flags=%b we=%b", out_tag, out_res, out_flags, out_flags_we);
        check("res", out_res, e.res);
        check("flags", {26'b0, out_flags & ((e.we == 6'b0) ? 6'b0 : 6'h3F)}, {26'b0, e.flags});
        check("flags_we", {26'b0, out_flags_we}, {26'b0, e.we});
        check("tag", {28'b0, out_tag}, {28'b0, e.tag});
        if (e.chk_lat) check("latency", cyc - e.acc_cyc, 32'd2);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic present(input logic [2:0] op, input logic [1:0] size, input logic [31:0] a,
                         input logic [4:0] cnt, input exp_t e);
    in_valid = 1'b1;
    in_op = op;
    in_size = size;
    in_a = a;
    in_cnt = cnt;
    in_tag = tag_ctr;
    pend = e;
    pend.tag = tag_ctr;
    pend.chk_lat = lat_on;
    accepted = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [31:0] a,
                      input logic [4:0] cnt, input exp_t e);
    present(op, size, a, cnt, e);
    for (int k = 0; k < 100 && !accepted; k++) cycle();
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=%0b, want accept within 100 cycles", in_ready);
    end
    in_valid = 1'b0;
    tag_ctr++;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) cycle();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want simulation end");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int acc, n0;
    logic [31:0] snap_res;
    logic [3:0]  snap_tag;

    vecs[0]  = '{3'd0, 2'd0, 32'h0000_0081, 5'd1,  32'h0000_0002, 6'b100001, 6'h3F};
    vecs[1]  = '{3'd2, 2'd1, 32'h0000_8000, 5'd20, 32'h0000_FFFF, 6'b010011, 6'h3F};
    // 0x21 does not fit the 5-bit count port; its masked value 1 is presented.
    vecs[2]  = '{3'd1, 2'd2, 32'h8000_0001, 5'd1,  32'h4000_0000, 6'b100011, 6'h3F};
    vecs[3]  = '{3'd4, 2'd0, 32'h0000_0001, 5'd9,  32'h0000_0080, 6'b100001, 6'h21};
    vecs[4]  = '{3'd3, 2'd2, 32'h1234_5678, 5'd0,  32'h1234_5678, 6'b000000, 6'h00};
    vecs[5]  = '{3'd0, 2'd0, 32'h0000_00FF, 5'd9,  32'h0000_0000, 6'b001010, 6'h3F};
    vecs[6]  = '{3'd1, 2'd1, 32'h0000_8000, 5'd16, 32'h0000_0000, 6'b101011, 6'h3F};
    vecs[7]  = '{3'd3, 2'd0, 32'h0000_0081, 5'd8,  32'h0000_0081, 6'b000001, 6'h21};
    vecs[8]  = '{3'd7, 2'd1, 32'h0000_4001, 5'd1,  32'h0000_8002, 6'b110000, 6'h3F};
    vecs[9]  = '{3'd2, 2'd0, 32'h0000_007F, 5'd3,  32'h0000_000F, 6'b000011, 6'h3F};
    vecs[10] = '{3'd4, 2'd1, 32'h0000_0001, 5'd16, 32'h0000_0001, 6'b000000, 6'h21};
    vecs[11] = '{3'd0, 2'd3, 32'h0000_0001, 5'd31, 32'h8000_0000, 6'b110010, 6'h3F};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 3'd0; in_size = 2'd0; in_a = 32'h0; in_cnt = 5'd0; in_tag = 4'd0;
    lat_on = 1'b1; rand_ready = 1'b0; accepted = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_res", out_res, 32'd0);
    check("rst_out_flags", {26'b0, out_flags}, 32'd0);
    check("rst_out_we", {26'b0, out_flags_we}, 32'd0);
    check("rst_out_tag", {28'b0, out_tag}, 32'd0);

    // Directed vectors, issued back-to-back with latency checked.
    for (int i = 0; i < 12; i++) begin
      e = '{default: 0};
      e.res = vecs[i].res;
      e.flags = vecs[i].flags;
      e.we = vecs[i].we;
      send(vecs[i].op, vecs[i].size, vecs[i].a, vecs[i].cnt, e);
    end
    drain();
    lat_on = 1'b0;

    // Back-pressure: 4 ops against a stalled consumer.
    out_ready = 1'b0;
    acc = 0;
    n0 = n_out;
    snap_res = 32'h0;
    snap_tag = 4'd0;
    for (int c = 0; c < 5; c++) begin
      if (acc < 4) present(3'd0, 2'd2, 32'h10 + 32'(acc), 5'(acc + 1),
                           model(3'd0, 2'd2, 32'h10 + 32'(acc), 5'(acc + 1)));
      cycle();
      if (accepted && in_valid) begin acc++; tag_ctr++; accepted = 1'b0; in_valid = 1'b0; end
      if (c == 2) begin snap_res = out_res; snap_tag = out_tag; end
    end
    check("bp_accepts", acc, 32'd2);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    check("bp_hold_res", out_res, snap_res);
    check("bp_hold_tag", {28'b0, out_tag}, {28'b0, snap_tag});
    out_ready = 1'b1;
    while (acc < 4) begin
      send(3'd0, 2'd2, 32'h10 + 32'(acc), 5'(acc + 1), model(3'd0, 2'd2, 32'h10 + 32'(acc), 5'(acc + 1)));
      acc++;
    end
    drain();
    check("bp_out_count", n_out - n0, 32'd4);

    // Flush with both stages full and a new request pending.
    out_ready = 1'b0;
    send(3'd1, 2'd0, 32'hF0, 5'd2, model(3'd1, 2'd0, 32'hF0, 5'd2));
    send(3'd3, 2'd1, 32'h1234, 5'd4, model(3'd3, 2'd1, 32'h1234, 5'd4));
    present(3'd0, 2'd0, 32'h1, 5'd1, model(3'd0, 2'd0, 32'h1, 5'd1));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_out_valid0", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    cycle();
    check("flush_out_valid1", {31'b0, out_valid}, 32'd0);
    cycle();
    check("flush_out_valid2", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(3'd2, 2'd1, 32'h8001, 5'd3, model(3'd2, 2'd1, 32'h8001, 5'd3));
    send(3'd4, 2'd2, 32'hDEAD_BEEF, 5'd7, model(3'd4, 2'd2, 32'hDEAD_BEEF, 5'd7));
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_out_res", out_res, 32'd0);
    check("arst_out_flags", {26'b0, out_flags}, 32'd0);
    check("arst_out_we", {26'b0, out_flags_we}, 32'd0);
    check("arst_out_tag", {28'b0, out_tag}, 32'd0);
    #1 rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    lat_on = 1'b1;
    send(3'd0, 2'd0, 32'h81, 5'd1, model(3'd0, 2'd0, 32'h81, 5'd1));
    drain();
    lat_on = 1'b0;

    // Randomized traffic with random consumer stalls.
    rand_ready = 1'b1;
    for (int r = 0; r < 200; r++) begin
      logic [2:0]  op;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [4:0]  cn;
      if ($urandom_range(0, 4) == 0) cycle();
      op = 3'($urandom_range(0, 7));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      cn = 5'($urandom_range(0, 31));
      send(op, sz, a, cn, model(op, sz, a, cn));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
